serial_cla_sequencer: RTL

SERIAL_CLA_SEQUENCER -- requirements
Module: serial_cla_sequencer

---
 rtl/cla_pkg.sv | 13 +
 rtl/cla_slice.sv | 31 +++
 rtl/serial_cla_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// Shared types and default widths for the serial carry-lookahead adder/subtractor.
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_BLOCK_SIZE = 4;

endpackage

// File: rtl/cla_slice.sv
// One lookahead slice: every carry is a flat sum-of-products of P, G and cin.
module cla_slice #(
  parameter int BLOCK_SIZE = 4
) (
  input  logic [BLOCK_SIZE-1:0] P,
  input  logic [BLOCK_SIZE-1:0] G,
  input  logic                  cin,
  output logic [BLOCK_SIZE:0]   carries
);

  logic acc;
  logic run;

  // Expand c[i+1] = G[i] | P[i]G[i-1] | ... | P[i..0]cin without using earlier carries.
  always_comb begin
    carries    = '0;
    carries[0] = cin;
    acc        = 1'b0;
    run        = 1'b0;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      acc = G[i];
      run = P[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (run & G[j]);
        run = run & P[j];
      end
      carries[i+1] = acc | (run & cin);
    end
  end

endmodule

// File: rtl/serial_cla_sequencer.sv
// Multi-cycle add/subtract, BLOCK_SIZE bits per cycle through a lookahead slice.
// Optional zero-result flag port enabled by defining SERIAL_CLA_ZERO_FLAG_EN.
module serial_cla_sequencer
  import cla_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int BLOCK_SIZE = DEFAULT_BLOCK_SIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  cout,
  output logic                  overflow,
`ifdef SERIAL_CLA_ZERO_FLAG_EN
  output logic                  zero,
`endif
  output logic                  busy
);

  localparam int NUM_SLICES = DATA_WIDTH / BLOCK_SIZE;
  localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  if (DATA_WIDTH % BLOCK_SIZE != 0) begin : g_width_check
    $fatal(1, "DATA_WIDTH must be a multiple of BLOCK_SIZE");
  end

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  carry_q, carry_d;
  logic                  cout_q, cout_d;
  logic                  overflow_q, overflow_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q, busy_d;
`ifdef SERIAL_CLA_ZERO_FLAG_EN
  logic                  zero_q, zero_d;
`endif

  logic [BLOCK_SIZE-1:0] slice_p;
  logic [BLOCK_SIZE-1:0] slice_g;
  logic [BLOCK_SIZE:0]   carries;

  always_comb begin
    slice_p = a_q[idx_q*BLOCK_SIZE +: BLOCK_SIZE] ^ b_q[idx_q*BLOCK_SIZE +: BLOCK_SIZE];
    slice_g = a_q[idx_q*BLOCK_SIZE +: BLOCK_SIZE] & b_q[idx_q*BLOCK_SIZE +: BLOCK_SIZE];
  end

  cla_slice #(
    .BLOCK_SIZE(BLOCK_SIZE)
  ) u_slice (
    .P      (slice_p),
    .G      (slice_g),
    .cin    (carry_q),
    .carries(carries)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    overflow_d  = overflow_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
`ifdef SERIAL_CLA_ZERO_FLAG_EN
    zero_d      = zero_q;
`endif
    case (state_q)
      IDLE: begin
        // Subtraction is a + ~b + 1: invert b here and seed the carry with sub.
        if (in_valid) begin
          a_d     = a;
          b_d     = b ^ {DATA_WIDTH{sub}};
          carry_d = sub;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*BLOCK_SIZE +: BLOCK_SIZE] = slice_p ^ carries[BLOCK_SIZE-1:0];
        carry_d = carries[BLOCK_SIZE];
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d       = '0;
          cout_d      = carries[BLOCK_SIZE];
          overflow_d  = carries[BLOCK_SIZE] ^ carries[BLOCK_SIZE-1];
          out_valid_d = 1'b1;
`ifdef SERIAL_CLA_ZERO_FLAG_EN
          zero_d      = (sum_d == '0);
`endif
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
`ifdef SERIAL_CLA_ZERO_FLAG_EN
          zero_d      = 1'b0;
`endif
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SERIAL_CLA_ZERO_FLAG_EN
      zero_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef SERIAL_CLA_ZERO_FLAG_EN
      zero_q      <= zero_d;
`endif
    end
  end

  // Gated by rst so in_ready is low during reset yet high the first cycle after it.
  assign in_ready  = (state_q == IDLE) & ~rst;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = overflow_q;
  assign busy      = busy_q;
`ifdef SERIAL_CLA_ZERO_FLAG_EN
  assign zero      = zero_q;
`endif

endmodule
